// File: rtl/f_node_pkg.sv
// Shared types and defaults for the F_node sequencer and its shadow register file.
package f_node_pkg;

    localparam int NUM_W_DEF   = 16;
    localparam int W_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_COMMIT,
        ST_ARMED,
        ST_EVAL_DRIVE,
        ST_EVAL_CAP
    } seq_state_t;

    typedef logic [W_WIDTH_DEF-1:0] w_slot_t;

endpackage

// File: rtl/f_node_shadow_regs.sv
// NUM_W x W_WIDTH shadow register file: one indexed write port, synchronous clear,
// flat packed read bus (slot k at bits [k*W_WIDTH +: W_WIDTH]).
module f_node_shadow_regs #(
    parameter int NUM_W   = 16,
    parameter int W_WIDTH = 5,
    parameter int IDX_W   = $clog2(NUM_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [W_WIDTH-1:0]         wr_data,
    output logic [NUM_W*W_WIDTH-1:0]   rd_bus
);

    logic [NUM_W-1:0][W_WIDTH-1:0] slots;

    always_ff @(posedge clk) begin
        if (reset) begin
            slots <= '0;
        end else begin
            for (int k = 0; k < NUM_W; k++) begin
                if (wr_en && wr_idx == IDX_W'(k))
                    slots[k] <= wr_data;
            end
        end
    end

    assign rd_bus = slots;

endmodule

// File: rtl/f_node_sequencer.sv
// Controller for one F_node: streams weights into shadow regs, commits them with a one-cycle
// write_enable, then runs drive/settle/capture evaluations. Optional abort port: F_SEQ_ABORT_EN.
module f_node_sequencer
    import f_node_pkg::*;
#(
    parameter int NUM_W   = NUM_W_DEF,
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int SETTLE  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef F_SEQ_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       w_valid,
    input  logic [W_WIDTH-1:0]         w_data,
    output logic                       w_ready,
    input  logic                       reload_req,
    input  logic                       eval_req,
    input  logic                       eval_in,
    output logic                       eval_ready,
    output logic                       write_enable,
    output logic [NUM_W*W_WIDTH-1:0]   write_bus,
    output logic                       node_in,
    input  logic [NUM_W*W_WIDTH-1:0]   out_bus,
    output logic [NUM_W*W_WIDTH-1:0]   result,
    output logic                       result_valid
);

    localparam int CNT_W = $clog2(NUM_W);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               abort_i;
    logic               beat;

`ifdef F_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign w_ready    = (state == ST_FILL);
    assign eval_ready = (state == ST_ARMED);
    assign beat       = w_valid && w_ready && !abort_i;

    f_node_shadow_regs #(
        .NUM_W   (NUM_W),
        .W_WIDTH (W_WIDTH),
        .IDX_W   (CNT_W)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (beat),
        .wr_idx  (cnt),
        .wr_data (w_data),
        .rd_bus  (write_bus)
    );

    // result/result_valid land together in EVAL_CAP: out_bus is sampled on the edge
    // that ends the last settle cycle, so the captured value is visible with the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_FILL;
            cnt          <= '0;
            settle_cnt   <= '0;
            write_enable <= 1'b0;
            node_in      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (abort_i) begin
                        cnt <= '0;
                    end else if (beat) begin
                        if (cnt == CNT_W'(NUM_W-1)) begin
                            cnt          <= '0;
                            state        <= ST_COMMIT;
                            write_enable <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: state <= ST_ARMED;
                ST_ARMED: begin
                    if (reload_req) begin
                        state <= ST_FILL;
                        cnt   <= '0;
                    end else if (eval_req) begin
                        node_in    <= eval_in;
                        settle_cnt <= '0;
                        state      <= ST_EVAL_DRIVE;
                    end
                end
                ST_EVAL_DRIVE: begin
                    if (abort_i) begin
                        node_in <= 1'b0;
                        state   <= ST_ARMED;
                    end else if (settle_cnt == SET_W'(SETTLE-1)) begin
                        result       <= out_bus;
                        result_valid <= 1'b1;
                        node_in      <= 1'b0;
                        state        <= ST_EVAL_CAP;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_EVAL_CAP: state <= ST_ARMED;
                default:     state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_f_node_sequencer.sv
// Randomised + directed bench for f_node_sequencer against a timestamp-based behavioural model.
module tb_f_node_sequencer;
    import f_node_pkg::*;

    localparam int NW = 16;
    localparam int WW = 5;
    localparam int ST = 1;
    localparam int BW = NW*WW;
    localparam logic [BW-1:0] PAT = {20{4'h5}};

    logic clk = 1'b0;
    logic reset, w_valid, reload_req, eval_req, eval_in, abort;
    w_slot_t w_data;
    logic w_ready, eval_ready, write_enable, node_in, result_valid;
    logic [BW-1:0] write_bus, out_bus, result;

    always #5 clk = ~clk;

    f_node_sequencer #(.NUM_W(NW), .W_WIDTH(WW), .SETTLE(ST)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef F_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .reload_req   (reload_req),
        .eval_req     (eval_req),
        .eval_in      (eval_in),
        .eval_ready   (eval_ready),
        .write_enable (write_enable),
        .write_bus    (write_bus),
        .node_in      (node_in),
        .out_bus      (out_bus),
        .result       (result),
        .result_valid (result_valid)
    );

    // Model: modes plus timestamps of the events each request schedules.
    int           m_fill, m_beats, m_commit, m_ready_from, m_drv_first, m_drv_last, m_cap;
    logic         m_drv_val;
    logic [BW-1:0] m_result;
    logic [WW-1:0] m_shadow [NW];

    int cyc = 0, checking = 0, fixed_ob = 0;
    int vectors = 0, miscompares = 0;
    int we_cnt = 0, last_we = -1, rv_cnt = 0, last_rv = -1, ni_cnt = 0;

    task automatic fail_line(input string nm, input string act, input string exp);
        miscompares++;
        $display("FAIL %s cyc=%0d got=%s exp=%s", nm, cyc, act, exp);
    endtask

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) fail_line(nm, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) fail_line(nm, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) fail_line(nm, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    function automatic logic [BW-1:0] m_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < NW; i++) b[i*WW +: WW] = m_shadow[i];
        return b;
    endfunction

    function automatic logic m_eval_ready();
        return (m_fill == 0) && (cyc >= m_ready_from);
    endfunction

    task automatic model_reset();
        m_fill = 1; m_beats = 0; m_commit = -1; m_ready_from = 0;
        m_drv_first = -1; m_drv_last = -1; m_cap = -1; m_drv_val = 1'b0;
        m_result = '0;
        for (int i = 0; i < NW; i++) m_shadow[i] = '0;
    endtask

    task automatic compare();
        logic exp_ni;
        exp_ni = (cyc >= m_drv_first && cyc <= m_drv_last) ? m_drv_val : 1'b0;
        chkb("w_ready", w_ready, m_fill != 0);
        chkb("eval_ready", eval_ready, m_eval_ready());
        chkb("write_enable", write_enable, cyc == m_commit);
        chkb("node_in", node_in, exp_ni);
        chkb("result_valid", result_valid, cyc == m_cap);
        chk("result", result, m_result);
        chk("write_bus", write_bus, m_bus());
        if (write_enable === 1'b1) begin we_cnt++; last_we = cyc; end
        if (result_valid === 1'b1) begin rv_cnt++; last_rv = cyc; end
        if (node_in === 1'b1) ni_cnt++;
    endtask

    // One clock cycle: check outputs of this cycle, drive its inputs, advance the model.
    task automatic step(input bit rst, input bit wv, input int wd, input bit rl, input bit er, input bit ei);
        bit rdy_now;
        @(negedge clk);
        if (checking != 0) compare();
        rdy_now    = m_eval_ready();
        reset      = rst;
        w_valid    = wv;
        w_data     = w_slot_t'(wd);
        reload_req = rl;
        eval_req   = er;
        eval_in    = ei;
        out_bus    = (fixed_ob != 0) ? PAT : BW'({$urandom(), $urandom(), $urandom()});
        if (rst) begin
            model_reset();
            checking = 1;
        end else begin
            if (m_fill != 0 && wv) begin
                m_shadow[m_beats] = w_slot_t'(wd);
                m_beats++;
                if (m_beats == NW) begin
                    m_beats = 0; m_fill = 0;
                    m_commit = cyc + 1; m_ready_from = cyc + 2;
                end
            end else if (rdy_now) begin
                if (rl) begin
                    m_fill = 1; m_beats = 0;
                end else if (er) begin
                    m_drv_first = cyc + 1; m_drv_last = cyc + ST; m_drv_val = ei;
                    m_cap = cyc + ST + 1; m_ready_from = cyc + ST + 2;
                end
            end
            if (cyc == m_drv_last) m_result = out_bus;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int f0, e0, we0, rv0, ni0, k;
        reset = 1'b1; w_valid = 1'b0; w_data = '0; reload_req = 1'b0;
        eval_req = 1'b0; eval_in = 1'b0; abort = 1'b0; out_bus = '0;
        model_reset();

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 9, 1, 1, 1);
        chkb("rst_w_ready", w_ready, 1'b1);
        chkb("rst_eval_ready", eval_ready, 1'b0);
        chkb("rst_write_enable", write_enable, 1'b0);
        chk("rst_result", result, '0);

        // Straight fill 1..16.
        f0 = cyc;
        for (int i = 1; i <= NW; i++) step(0, 1, i, 0, 0, 0);
        idle(2);
        chki("commit_latency", last_we - f0, 16);
        chki("commit_once", we_cnt, 1);
        chki("slot0", int'(write_bus[4:0]), 1);
        chki("slot15", int'(write_bus[79:75]), 16);
        chkb("armed_after_commit", eval_ready, 1'b1);

        // Evaluation with fixed out_bus pattern.
        fixed_ob = 1;
        rv0 = rv_cnt; ni0 = ni_cnt; e0 = cyc;
        step(0, 0, 0, 0, 1, 1);
        idle(3);
        chki("eval_latency", last_rv - e0, 2);
        chki("eval_rv_once", rv_cnt - rv0, 1);
        chki("eval_ni_cycles", ni_cnt - ni0, 1);
        chk("eval_result", result, PAT);
        chkb("eval_ni_low", node_in, 1'b0);
        fixed_ob = 0;

        // Reload and eval together: reload wins.
        ni0 = ni_cnt; rv0 = rv_cnt;
        step(0, 0, 0, 1, 1, 1);
        idle(1);
        chkb("coll_w_ready", w_ready, 1'b1);
        chki("coll_no_node_in", ni_cnt - ni0, 0);

        // Backpressured fill, w_valid kept high past the commit.
        we0 = we_cnt; k = 0;
        while (k < NW) begin
            if ($urandom_range(0, 2) == 0) step(0, 0, 0, 0, 0, 0);
            else begin step(0, 1, (k*3 + 2) % 32, 0, 0, 0); k++; end
        end
        for (int i = 0; i < 6; i++) step(0, 1, 31, 0, 0, 0);
        chki("bp_commit_once", we_cnt - we0, 1);
        chki("bp_slot7", int'(write_bus[7*WW +: WW]), 23);
        chki("bp_slot15", int'(write_bus[15*WW +: WW]), 15);

        // Reset after 7 beats of a refill, then a complete refill.
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 20 + i, 0, 0, 0);
        we0 = we_cnt;
        step(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("rst_fill_bus_clr", write_bus, '0);
        for (int i = 0; i < NW; i++) step(0, 1, 31 - i, 0, 0, 0);
        idle(2);
        chki("refill_commit_once", we_cnt - we0, 1);
        chki("refill_slot0", int'(write_bus[4:0]), 31);
        chki("refill_slot15", int'(write_bus[79:75]), 16);

        // Reset while IN is being driven.
        rv0 = rv_cnt;
        step(0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        chkb("rst_eval_node_in", node_in, 1'b0);
        chki("rst_eval_no_rv", rv_cnt - rv0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);

        @(negedge clk);
        compare();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
